pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Next-generation fetch-PC block for the five-stage MIPS pipeline.
- Owns the F-stage PC register and computes the next PC from D-stage control flow (branch/J/JR), exceptions and ERET.
- Tracks the branch-delay-slot status of the F instruction for CP0.
- Optionally checks fetch addresses for AdEL.
- Sits between the IM address port, the D-stage controller/comparator and CP0.

Parameters:
RESET_PC, 32'h0000_3000, F_PC value after reset.
EXC_VEC, 32'h0000_4180, exception handler entry address.
IM_BASE, 32'h0000_3000, lowest legal fetch address.
IM_SIZE, 32'h0000_4000, legal fetch window size in bytes; legal range is [IM_BASE, IM_BASE+IM_SIZE).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hazard stall; freeze F_PC and F_BD.
D_PC  in  32  PC of the instruction in D.
NPCOp  in  3  D control-flow select: 0=PC4, 1=BR, 2=J, 3=JR; 4..7 behave as PC4.
Imm  in  26  D instr[25:0].
RA  in  32  forwarded rs value for JR.
b_jump  in  1  branch condition from the D comparator.
exc_req  in  1  CP0 exception request.
eret  in  1  ERET in the commit stage.
EPC  in  32  CP0 EPC.
F_PC  out  32  registered fetch PC.
NPC  out  32  combinational next-PC (debug/observe).
PC8  out  32  D_PC + 8; link address.
F_BD  out  1  registered; F instruction is a delay slot.
F_AdEL  out  1  fetch address error for F_PC.
redirect  out  1  combinational; exc_req | eret; flush pulse for F/D/E/M.

Behaviour:
Reset values:
- F_PC = RESET_PC.
- F_BD = 0.
- F_AdEL = 0.
- NPC and PC8 are combinational from their inputs and are not reset.

Next-PC arithmetic (all modulo 2^32; wrap-around is silent, no flag):
- PC4: F_PC + 4.
- BR with b_jump=1: D_PC + 4 + (sign-extended Imm[15:0] << 2).
- BR with b_jump=0: F_PC + 4.
- J: {D_PC[31:28], Imm, 2'b00}.
- JR: RA, used unmodified; misalignment is detected only by F_AdEL.
- NPCOp 4..7: F_PC + 4.

Register update each rising edge, in strict priority order:
1. reset: F_PC <= RESET_PC, F_BD <= 0.
2. exc_req: F_PC <= EXC_VEC, F_BD <= 0. Overrides stall and eret.
3. eret: F_PC <= EPC, F_BD <= 0. Overrides stall.
4. stall: F_PC and F_BD hold. NPCOp/b_jump are re-evaluated next cycle because D is frozen.
5. Otherwise: F_PC <= NPC; F_BD <= (NPCOp in {1,2,3}). F_BD is set whether or not the branch is taken.

Other rules:
- redirect = exc_req | eret, same cycle, independent of stall and reset.
- Simultaneous exc_req and eret: the exception wins; the ERET is discarded.
- Reset mid-stall or mid-redirect: reset wins unconditionally.
- The delay slot is always fetched. The taken target is the PC after the slot, with no extra cycle.
- Latency: NPC is valid in the same cycle its inputs are; F_PC updates one cycle later.
- The state machine is implicit in (F_PC, F_BD). No other state is held.

Optional Feature:
PC_FETCH_CHECK_EN
- Defined: F_AdEL = (F_PC[1:0] != 0) | (F_PC < IM_BASE) | (F_PC >= IM_BASE + IM_SIZE). Comparisons are unsigned, computed combinationally from the registered F_PC. The block does not itself redirect on AdEL; CP0 raises exc_req.
- Undefined: F_AdEL is tied to 0 and no comparator logic is generated.

Test Plan:
- Reset held 2 cycles, then released, with NPCOp=0 and no stall: F_PC sequence is 0x3000, 0x3004, 0x3008, and F_BD stays 0.
- D_PC=0x3000, F_PC=0x3004, NPCOp=1, b_jump=1, Imm[15:0]=0xFFFF: next F_PC = 0x3000. With b_jump=0: next F_PC = 0x3008. F_BD=1 in both cases.
- NPCOp=2, D_PC=0x3010, Imm=26'h0000D00: next F_PC = 0x3400. Then NPCOp=3, RA=0x3abc: next F_PC = 0x3abc.
- stall=1 for 3 cycles with NPCOp=1, b_jump=1: F_PC and F_BD unchanged.
  - Same window with exc_req=1 in cycle 2: F_PC = 0x4180 next edge, F_BD=0, redirect=1 only in that cycle.
- exc_req=1 and eret=1 together with EPC=0x3020: F_PC = 0x4180. Then eret alone: F_PC = 0x3020.
- With PC_FETCH_CHECK_EN: JR to RA=0x3002 gives F_AdEL=1; RA=0x7000 gives F_AdEL=1; RA=0x3ffc gives F_AdEL=0. Without the macro: F_AdEL=0 for all three.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch-PC register and next-PC select for the 5-stage MIPS pipeline.
// Optional fetch-address check enabled by macro PC_FETCH_CHECK_EN.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] D_PC,
  input  logic [2:0]  NPCOp,
  input  logic [25:0] Imm,
  input  logic [31:0] RA,
  input  logic        b_jump,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] EPC,
  output logic [31:0] F_PC,
  output logic [31:0] NPC,
  output logic [31:0] PC8,
  output logic        F_BD,
  output logic        F_AdEL,
  output logic        redirect
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        is_br, is_j, is_jr;

  if (IM_SIZE == 32'd0 || IM_BASE[1:0] != 2'b00) begin : g_bad_cfg
    $error("pc_redirect_unit: bad fetch window");
  end

  assign is_br = (NPCOp == 3'd1);
  assign is_j  = (NPCOp == 3'd2);
  assign is_jr = (NPCOp == 3'd3);

  assign pc4    = pc_q + 32'd4;
  assign br_tgt = D_PC + 32'd4
                + {{14{Imm[15]}}, Imm[15:0], 2'b00};
  assign j_tgt  = {D_PC[31:28], Imm, 2'b00};
  assign PC8    = D_PC + 32'd8;

  always_comb begin
    NPC = pc4;
    unique case (1'b1)
      is_br & b_jump: NPC = br_tgt;
      is_j:           NPC = j_tgt;
      is_jr:          NPC = RA;
      default:        NPC = pc4;
    endcase
  end

  // Exception beats ERET, and both beat a hazard stall.
  always_comb begin
    pc_d = pc_q;
    bd_d = bd_q;
    if (exc_req) begin
      pc_d = EXC_VEC;
      bd_d = 1'b0;
    end else if (eret) begin
      pc_d = EPC;
      bd_d = 1'b0;
    end else if (!stall) begin
      pc_d = NPC;
      bd_d = is_br | is_j | is_jr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      bd_q <= bd_d;
    end
  end

  assign F_PC     = pc_q;
  assign F_BD     = bd_q;
  assign redirect = exc_req | eret;

`ifdef PC_FETCH_CHECK_EN
  localparam logic [31:0] IM_END = IM_BASE + IM_SIZE;
  assign F_AdEL = (pc_q[1:0] != 2'b00)
                | (pc_q < IM_BASE)
                | (pc_q >= IM_END);
`else
  assign F_AdEL = 1'b0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit.
// Expected F_AdEL follows PC_FETCH_CHECK_EN.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset, stall, b_jump, exc_req, eret;
  logic [31:0] D_PC, RA, EPC;
  logic [2:0]  NPCOp;
  logic [25:0] Imm;
  logic [31:0] F_PC, NPC, PC8;
  logic        F_BD, F_AdEL, redirect;

  int ncmp = 0;
  int nerr = 0;

`ifdef PC_FETCH_CHECK_EN
  localparam logic ADEL_ON = 1'b1;
`else
  localparam logic ADEL_ON = 1'b0;
`endif

  pc_redirect_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .D_PC(D_PC), .NPCOp(NPCOp), .Imm(Imm),
    .RA(RA), .b_jump(b_jump), .exc_req(exc_req),
    .eret(eret), .EPC(EPC), .F_PC(F_PC),
    .NPC(NPC), .PC8(PC8), .F_BD(F_BD),
    .F_AdEL(F_AdEL), .redirect(redirect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_f(input string tag,
                       input logic [31:0] pc,
                       input logic bd);
    chk({tag, "_pc"}, F_PC, pc);
    chk({tag, "_bd"}, {31'd0, F_BD}, {31'd0, bd});
  endtask

  initial begin
    reset = 1; stall = 0; b_jump = 0;
    exc_req = 0; eret = 0;
    D_PC = 0; RA = 0; EPC = 0;
    NPCOp = 0; Imm = 0;
    step(); step();
    chk_f("rst", 32'h3000, 1'b0);
    chk("rst_adel", {31'd0, F_AdEL}, 32'd0);
    chk("rst_redir", {31'd0, redirect}, 32'd0);
    reset = 0;
    step(); chk_f("seq1", 32'h3004, 1'b0);
    step(); chk_f("seq2", 32'h3008, 1'b0);

    reset = 1; step(); reset = 0;
    step(); chk_f("pre_br", 32'h3004, 1'b0);
    D_PC = 32'h3000; NPCOp = 3'd1;
    b_jump = 1; Imm = 26'h000FFFF;
    #1; chk("br_npc", NPC, 32'h3000);
    chk("pc8", PC8, 32'h3008);
    step(); chk_f("br_t", 32'h3000, 1'b1);
    NPCOp = 3'd0; b_jump = 0;
    step(); chk_f("pre_nt", 32'h3004, 1'b0);
    NPCOp = 3'd1;
    #1; chk("nt_npc", NPC, 32'h3008);
    step(); chk_f("br_nt", 32'h3008, 1'b1);

    NPCOp = 3'd2; D_PC = 32'h3010; Imm = 26'h0000D00;
    step(); chk_f("j", 32'h3400, 1'b1);
    NPCOp = 3'd3; RA = 32'h3abc;
    step(); chk_f("jr", 32'h3abc, 1'b1);

    NPCOp = 3'd1; b_jump = 1; stall = 1;
    D_PC = 32'h3ab8; Imm = 26'h0000010;
    #1; chk("st_npc", NPC, 32'h3afc);
    chk("st_pc8", PC8, 32'h3ac0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_f("stall", 32'h3abc, 1'b1);
      chk("st_redir", {31'd0, redirect}, 32'd0);
    end
    step(); chk_f("stw1", 32'h3abc, 1'b1);
    exc_req = 1;
    #1; chk("stw_redir", {31'd0, redirect}, 32'd1);
    step(); chk_f("stw_exc", 32'h4180, 1'b0);
    exc_req = 0;
    #1; chk("stw_redir0", {31'd0, redirect}, 32'd0);
    step(); chk_f("stw3", 32'h4180, 1'b0);

    stall = 0; b_jump = 0;
    NPCOp = 3'd2; D_PC = 32'h3010; Imm = 26'h0000D00;
    step(); chk_f("j2", 32'h3400, 1'b1);
    NPCOp = 3'd0; exc_req = 1; eret = 1;
    EPC = 32'h3020;
    step(); chk_f("exc_eret", 32'h4180, 1'b0);
    exc_req = 0; eret = 0;
    NPCOp = 3'd3; RA = 32'h3abc;
    step(); chk_f("jr2", 32'h3abc, 1'b1);
    NPCOp = 3'd1; b_jump = 1; stall = 1; eret = 1;
    #1; chk("eret_redir", {31'd0, redirect}, 32'd1);
    step(); chk_f("eret", 32'h3020, 1'b0);
    eret = 0; stall = 0; NPCOp = 3'd5;
    step(); chk_f("op5", 32'h3024, 1'b0);

    reset = 1; stall = 1; exc_req = 1;
    #1; chk("rst_redir1", {31'd0, redirect}, 32'd1);
    step(); chk_f("rst_mid", 32'h3000, 1'b0);
    reset = 0; stall = 0; exc_req = 0; b_jump = 0;

    NPCOp = 3'd3; RA = 32'hFFFF_FFFC;
    step(); chk_f("wrap0", 32'hFFFF_FFFC, 1'b1);
    chk("adel_hi", {31'd0, F_AdEL}, {31'd0, ADEL_ON});
    NPCOp = 3'd0;
    step(); chk_f("wrap1", 32'h0000_0000, 1'b0);
    chk("adel_lo", {31'd0, F_AdEL}, {31'd0, ADEL_ON});

    NPCOp = 3'd3; RA = 32'h3002;
    step(); chk("adel_mis", {31'd0, F_AdEL}, {31'd0, ADEL_ON});
    RA = 32'h7000;
    step(); chk("adel_end", {31'd0, F_AdEL}, {31'd0, ADEL_ON});
    RA = 32'h3ffc;
    step(); chk("adel_ok", {31'd0, F_AdEL}, 32'd0);
    chk("adel_ok_pc", F_PC, 32'h3ffc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
